// File: rtl/key_event_tracker.sv
// Registered keyboard event tracker: held level, press/release pulses and frame-paced auto-repeat per key.
// Define KEY_EVENT_REPEAT_EN to compile in the auto-repeat FSMs; otherwise repeat_ev is tied low.
module key_event_tracker #(
  parameter int                      NUM_SLOTS    = 4,
  parameter int                      NUM_KEYS     = 6,
  parameter logic [8*NUM_KEYS-1:0]   KEY_CODES    = {8'h50, 8'h4F, 8'h52, 8'h07, 8'h04, 8'h1A},
  parameter int                      REPEAT_DELAY = 15,
  parameter int                      REPEAT_RATE  = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [8*NUM_SLOTS-1:0] keycode,
  input  logic                   keycode_valid,
  input  logic                   frame_tick,
  output logic [NUM_KEYS-1:0]    held,
  output logic [NUM_KEYS-1:0]    pressed,
  output logic [NUM_KEYS-1:0]    released,
  output logic [NUM_KEYS-1:0]    repeat_ev,
  output logic                   any_held,
  output logic                   rollover
);

  logic [NUM_KEYS-1:0] match;
  logic                rollover_rpt;
  logic                upd;
  logic [NUM_KEYS-1:0] press_ev;
  logic [NUM_KEYS-1:0] rel_ev;

  // A code of 8'h00 marks an unused key and must never match an empty slot.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (KEY_CODES[8*k +: 8] != 8'h00 && keycode[8*s +: 8] == KEY_CODES[8*k +: 8])
          match[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rollover_rpt = 1'b1;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (keycode[8*s +: 8] != 8'h01)
        rollover_rpt = 1'b0;
    end
  end

  assign upd      = keycode_valid & ~rollover_rpt;
  assign press_ev = upd ? (match & ~held) : '0;
  assign rel_ev   = upd ? (~match & held) : '0;
  assign any_held = |held;

  // Report capture stage: level and edge pulses land one cycle after the strobe
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      held     <= '0;
      pressed  <= '0;
      released <= '0;
      rollover <= 1'b0;
    end else begin
      pressed  <= press_ev;
      released <= rel_ev;
      if (upd)
        held <= match;
      if (keycode_valid)
        rollover <= rollover_rpt;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rpt
    rpt_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             rpt_q;

    assign cnt_inc      = cnt + 1'b1;
    assign repeat_ev[k] = rpt_q;

    // Release wins over a coincident frame_tick so no stray pulse follows key-up.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state <= ST_IDLE;
        cnt   <= '0;
        rpt_q <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (rel_ev[k]) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (press_ev[k]) begin
                state <= ST_DELAY;
                cnt   <= '0;
              end
            end
            ST_DELAY: begin
              if (frame_tick) begin
                if (cnt_inc == DELAY_C) begin
                  rpt_q <= 1'b1;
                  state <= ST_REPEAT;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt_inc;
                end
              end
            end
            ST_REPEAT: begin
              if (frame_tick) begin
                if (cnt_inc == RATE_C) begin
                  rpt_q <= 1'b1;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt_inc;
                end
              end
            end
            default: begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign repeat_ev         = '0;
`endif

endmodule

// File: doc/key_event_tracker.md
# key_event_tracker

Parametrised keyboard event block between the USB keycode register (HID boot-report key slots) and the game logic. For each of NUM_KEYS configurable key codes it tracks a registered held level, single-cycle press and release events, and an optional frame-paced auto-repeat event. It replaces ad-hoc per-key combinational compares with a single registered, edge-aware interface.

## Interface
Parameters:
- NUM_SLOTS, 4, number of 8-bit key slots in the keycode word.
- NUM_KEYS, 6, number of tracked keys.
- KEY_CODES, {8'h50,8'h4F,8'h52,8'h07,8'h04,8'h1A}, packed 8*NUM_KEYS codes; key i = KEY_CODES[8*i+7:8*i], so default key0=W(1A), key1=A(04), key2=D(07), key3=Up(52), key4=Right(4F), key5=Left(50).
- REPEAT_DELAY, 15, frame ticks from press to first repeat (>=1).
- REPEAT_RATE, 4, frame ticks between subsequent repeats (>=1).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- keycode  in  8*NUM_SLOTS  current report; slot s = keycode[8*s+7:8*s].
- keycode_valid  in  1  one-cycle strobe, keycode is stable and new.
- frame_tick  in  1  one-cycle pulse per video frame (repeat time base).
- held  out  NUM_KEYS  registered key-down level.
- pressed  out  NUM_KEYS  one-cycle pulse on 0->1 of held.
- released  out  NUM_KEYS  one-cycle pulse on 1->0 of held.
- repeat_ev  out  NUM_KEYS  one-cycle auto-repeat pulse.
- any_held  out  1  OR of held.
- rollover  out  1  registered: last valid report was a rollover error.

## Operation
- Match: key i matches if any slot equals its code; code 8'h00 in KEY_CODES never matches (unused key).
- Rollover: a report with all slots == 8'h01 is an error report; held is left unchanged, no pressed/released, rollover set to 1. Any other valid report clears rollover.
- On keycode_valid (non-rollover): held <= match; pressed <= match & ~held; released <= ~match & held. Cycles without keycode_valid: held unchanged, pressed/released 0.
- Per-key repeat FSM, states IDLE, DELAY, REPEAT, counter width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
  - IDLE: on press event -> DELAY, cnt=0.
  - DELAY: each frame_tick cnt++; when cnt reaches REPEAT_DELAY, pulse repeat_ev, -> REPEAT, cnt=0.
  - REPEAT: each frame_tick cnt++; at REPEAT_RATE pulse repeat_ev, cnt=0.
  - Any state: release event -> IDLE, cnt=0; release has priority over a same-cycle frame_tick (no repeat pulse).
- pressed never coincides with repeat_ev for the same key.
- Reset mid-hold: all outputs 0, FSMs IDLE; next valid report still containing the key produces a fresh pressed.

## Timing
- Reset values: held, pressed, released, repeat_ev, any_held, rollover all 0.
- Latency: keycode_valid at edge N -> held/pressed/released/rollover visible after edge N+1 (1 cycle); any_held follows held the same cycle (combinational OR of registers).
- First repeat_ev: registered, the cycle after the REPEAT_DELAY-th frame_tick following the press; then every REPEAT_RATE ticks.
- Frame_tick in the same cycle as the press keycode_valid is not counted.
- Back-to-back keycode_valid supported every cycle.

## Configuration
- KEY_EVENT_REPEAT_EN defined: repeat FSMs and counters compiled in, behaviour as above.
- Undefined: no FSMs/counters; repeat_ev tied to 0; frame_tick ignored; REPEAT_* parameters unused. All other behaviour identical.

## Test plan
- Reset, then keycode=32'h0000001A with valid -> held=6'b000001, pressed=000001 for one cycle, any_held=1.
- Report 32'h04000007 then 32'h00000000 -> held=000110, pressed=000110; then released=000110 for one cycle, held=0.
- Rollover 32'h01010101 while W held -> held stays 000001, no pulses, rollover=1; next normal report clears it.
- REPEAT_EN, hold Up, 15 frame_ticks -> repeat_ev[3] after 15th tick, then after ticks 19, 23; release concurrent with tick 27 -> no pulse, FSM IDLE.
- Assert Reset while Right held -> all outputs 0 immediately; next valid with 8'h4F -> pressed[4]=1.
- Key code 8'h00 in slot with KEY_CODES entry 8'h00 (custom parameter) -> never held.
